aq_jpeg_rgb2ycbcr: RTL and testbench

Encoder-side colour converter: accepts raster RGB pixels with pixel coordinates and emits level-shifted signed Y/Cb/Cr samples. Alongside each sample it emits the MCU block coordinates and the in-MCU buffer addresses that the JPEG block writer needs. It supports 4:4:4, 4:2:2 (W=2) and 4:2:0 (W=2, H=2) layouts. Chroma subsampling is done by decimation: the top-left pixel of each subsampling cell is kept. The result feeds the forward-DCT block buffer.

---
 rtl/aq_jpeg_rgb2ycbcr_if.sv | 36 +++
 rtl/aq_jpeg_rgb2ycbcr.sv | 120 ++++++++++++
 tb/tb_aq_jpeg_rgb2ycbcr.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/aq_jpeg_rgb2ycbcr_if.sv
// Pixel-stream bundle for the RGB to YCbCr converter: raster RGB pixels in,
// level-shifted Y/Cb/Cr samples with MCU block coordinates and buffer addresses out.
interface aq_jpeg_rgb2ycbcr_if;
  logic [1:0]        SubSamplingW;
  logic [1:0]        SubSamplingH;
  logic              InValid;
  logic              InReady;
  logic [15:0]       InPixelX;
  logic [15:0]       InPixelY;
  logic [7:0]        InR;
  logic [7:0]        InG;
  logic [7:0]        InB;
  logic              OutReady;
  logic              OutValid;
  logic [11:0]       OutBlockX;
  logic [11:0]       OutBlockY;
  logic [7:0]        OutAddressY;
  logic [7:0]        OutAddressCbCr;
  logic              OutChromaValid;
  logic              OutMcuLast;
  logic signed [8:0] OutY;
  logic signed [8:0] OutCb;
  logic signed [8:0] OutCr;

  modport slave (
    input  SubSamplingW, SubSamplingH, InValid, InPixelX, InPixelY, InR, InG, InB, OutReady,
    output InReady, OutValid, OutBlockX, OutBlockY, OutAddressY, OutAddressCbCr,
           OutChromaValid, OutMcuLast, OutY, OutCb, OutCr
  );

  modport master (
    output SubSamplingW, SubSamplingH, InValid, InPixelX, InPixelY, InR, InG, InB, OutReady,
    input  InReady, OutValid, OutBlockX, OutBlockY, OutAddressY, OutAddressCbCr,
           OutChromaValid, OutMcuLast, OutY, OutCb, OutCr
  );
endinterface

// File: rtl/aq_jpeg_rgb2ycbcr.sv
// Q14 RGB to level-shifted YCbCr converter with MCU addressing for 4:4:4 / 4:2:2 / 4:2:0.
// Stages: S0 input+address, S1 products, S2 sums, S3 shift/saturate, then output register.
module aq_jpeg_rgb2ycbcr (
  input  logic clk,
  input  logic rst,
  aq_jpeg_rgb2ycbcr_if.slave bus
);
  typedef struct packed {
    logic [11:0] bx;
    logic [11:0] by;
    logic [7:0]  ay;
    logic [7:0]  ac;
    logic        cv;
    logic        ml;
  } meta_t;

  // Product order: Y(R,G,B), Cb(R,G,B), Cr(R,G,B); signs are applied in S2.
  localparam logic [13:0] COEF [9] = '{14'd4899, 14'd9617, 14'd1868,
                                       14'd2765, 14'd5427, 14'd8192,
                                       14'd8192, 14'd6860, 14'd1332};

  function automatic logic signed [8:0] sat9(input logic signed [23:0] v);
    logic signed [8:0] r;
    if (v > 24'sd127)       r = 9'sd127;
    else if (v < -24'sd128) r = -9'sd128;
    else                    r = v[8:0];
    return r;
  endfunction

  function automatic logic signed [23:0] ext(input logic [21:0] p);
    return $signed({2'b00, p});
  endfunction

  logic              adv_s, w2_s, h2_s;
  logic [2:0]        crow_s, ccol_s;
  meta_t             meta_in_s;
  logic              s0_valid_q, s1_valid_q, s2_valid_q, s3_valid_q, out_valid_q;
  meta_t             s0_meta_q, s1_meta_q, s2_meta_q, s3_meta_q, out_meta_q;
  logic [7:0]        s0_pix_q  [3];
  logic [21:0]       s1_prod_q [9];
  logic [21:0]       s1_prod_d [9];
  logic signed [23:0] s2_y_q, s2_cb_q, s2_cr_q, s2_y_d, s2_cb_d, s2_cr_d;
  logic signed [8:0]  s3_y_q, s3_cb_q, s3_cr_q, s3_y_d, s3_cb_d, s3_cr_d;
  logic signed [8:0]  out_y_q, out_cb_q, out_cr_q;

  assign adv_s       = bus.OutReady;
  assign bus.InReady = bus.OutReady;

  // Address fields from the raw coordinates and the per-pixel sampling ratios.
  always_comb begin
    w2_s   = (bus.SubSamplingW == 2'd2);
    h2_s   = (bus.SubSamplingH == 2'd2);
    crow_s = h2_s ? bus.InPixelY[3:1] : bus.InPixelY[2:0];
    ccol_s = w2_s ? bus.InPixelX[3:1] : bus.InPixelX[2:0];
    meta_in_s.bx = w2_s ? bus.InPixelX[15:4] : bus.InPixelX[14:3];
    meta_in_s.by = h2_s ? bus.InPixelY[15:4] : bus.InPixelY[14:3];
    meta_in_s.ay = {(h2_s ? bus.InPixelY[3:0] : {1'b0, bus.InPixelY[2:0]}),
                    (w2_s ? bus.InPixelX[3:0] : {1'b0, bus.InPixelX[2:0]})};
    meta_in_s.ac = {crow_s, 1'b0, ccol_s, 1'b0};
    meta_in_s.cv = (!w2_s || !bus.InPixelX[0]) && (!h2_s || !bus.InPixelY[0]);
    meta_in_s.ml = (w2_s ? (bus.InPixelX[3:0] == 4'd15) : (bus.InPixelX[2:0] == 3'd7)) &&
                   (h2_s ? (bus.InPixelY[3:0] == 4'd15) : (bus.InPixelY[2:0] == 3'd7));
  end

  // Arithmetic datapath: products, signed sums with rounding, floor shift and clamp.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      s1_prod_d[i] = 22'(s0_pix_q[i % 3]) * 22'(COEF[i]);
    end
    s2_y_d  = 24'sd8192 + ext(s1_prod_q[0]) + ext(s1_prod_q[1]) + ext(s1_prod_q[2]);
    s2_cb_d = 24'sd8192 - ext(s1_prod_q[3]) - ext(s1_prod_q[4]) + ext(s1_prod_q[5]);
    s2_cr_d = 24'sd8192 + ext(s1_prod_q[6]) - ext(s1_prod_q[7]) - ext(s1_prod_q[8]);
    s3_y_d  = sat9((s2_y_q >>> 14) - 24'sd128);
    s3_cb_d = sat9(s2_cb_q >>> 14);
    s3_cr_d = sat9(s2_cr_q >>> 14);
  end

  // Pipeline registers; every stage holds while downstream is not ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_valid_q <= 1'b0; s1_valid_q <= 1'b0; s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0; out_valid_q <= 1'b0;
      s0_meta_q <= '0; s1_meta_q <= '0; s2_meta_q <= '0; s3_meta_q <= '0; out_meta_q <= '0;
      for (int i = 0; i < 3; i++) s0_pix_q[i] <= 8'd0;
      for (int i = 0; i < 9; i++) s1_prod_q[i] <= 22'd0;
      s2_y_q <= 24'sd0; s2_cb_q <= 24'sd0; s2_cr_q <= 24'sd0;
      s3_y_q <= 9'sd0;  s3_cb_q <= 9'sd0;  s3_cr_q <= 9'sd0;
      out_y_q <= 9'sd0; out_cb_q <= 9'sd0; out_cr_q <= 9'sd0;
    end else if (adv_s) begin
      s0_valid_q  <= bus.InValid;
      s0_meta_q   <= meta_in_s;
      s0_pix_q[0] <= bus.InR;
      s0_pix_q[1] <= bus.InG;
      s0_pix_q[2] <= bus.InB;
      s1_valid_q  <= s0_valid_q;
      s1_meta_q   <= s0_meta_q;
      for (int i = 0; i < 9; i++) s1_prod_q[i] <= s1_prod_d[i];
      s2_valid_q  <= s1_valid_q;
      s2_meta_q   <= s1_meta_q;
      s2_y_q <= s2_y_d; s2_cb_q <= s2_cb_d; s2_cr_q <= s2_cr_d;
      s3_valid_q  <= s2_valid_q;
      s3_meta_q   <= s2_meta_q;
      s3_y_q <= s3_y_d; s3_cb_q <= s3_cb_d; s3_cr_q <= s3_cr_d;
      out_valid_q <= s3_valid_q;
      out_meta_q  <= s3_meta_q;
      out_y_q <= s3_y_q; out_cb_q <= s3_cb_q; out_cr_q <= s3_cr_q;
    end
  end

  assign bus.OutValid       = out_valid_q;
  assign bus.OutBlockX      = out_meta_q.bx;
  assign bus.OutBlockY      = out_meta_q.by;
  assign bus.OutAddressY    = out_meta_q.ay;
  assign bus.OutAddressCbCr = out_meta_q.ac;
  assign bus.OutChromaValid = out_meta_q.cv;
  assign bus.OutMcuLast     = out_meta_q.ml;
  assign bus.OutY           = out_y_q;
  assign bus.OutCb          = out_cb_q;
  assign bus.OutCr          = out_cr_q;
endmodule

// File: tb/tb_aq_jpeg_rgb2ycbcr.sv
// Self-checking bench for aq_jpeg_rgb2ycbcr: directed vector table, stall and reset
// sequences, and randomized traffic against an arithmetic reference model.
module tb_aq_jpeg_rgb2ycbcr;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aq_jpeg_rgb2ycbcr_if bus();
  aq_jpeg_rgb2ycbcr dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int y, cb, cr, bx, by, ay, ac, cv, ml;
    int acc;
  } exp_t;

  typedef struct {
    int r, g, b, x, y, w, h;
    int ey, ecb, ecr, ebx, eby, eay, eac, ecv, eml;
  } vec_t;

  int     checks = 0;
  int     errors = 0;
  int     ready_edges = 0;
  exp_t   q[$];
  exp_t   nil;
  vec_t   tbl[10];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int floordiv(input int n);
    return (n >= 0) ? n / 16384 : -((-n + 16383) / 16384);
  endfunction

  function automatic int clamp(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  // Reference: colour matrix with floor rounding, MCU geometry from cell sizes.
  function automatic exp_t model(input int r, g, b, x, y, w, h);
    exp_t e;
    bit w2 = (w == 2);
    bit h2 = (h == 2);
    int mw = w2 ? 16 : 8;
    int mh = h2 ? 16 : 8;
    e.y  = clamp(floordiv(4899*r + 9617*g + 1868*b + 8192) - 128);
    e.cb = clamp(floordiv(-2765*r - 5427*g + 8192*b + 8192));
    e.cr = clamp(floordiv(8192*r - 6860*g - 1332*b + 8192));
    e.bx = (x / mw) % 4096;
    e.by = (y / mh) % 4096;
    e.ay = (y % mh) * 16 + (x % mw);
    e.ac = ((y % mh) / (h2 ? 2 : 1)) * 32 + ((x % mw) / (w2 ? 2 : 1)) * 2;
    e.cv = ((!w2 || (x % 2 == 0)) && (!h2 || (y % 2 == 0))) ? 1 : 0;
    e.ml = ((x % mw == mw - 1) && (y % mh == mh - 1)) ? 1 : 0;
    e.acc = 0;
    return e;
  endfunction

  function automatic logic [69:0] outs();
    return {bus.OutValid, bus.OutBlockX, bus.OutBlockY, bus.OutAddressY, bus.OutAddressCbCr,
            bus.OutChromaValid, bus.OutMcuLast, bus.OutY, bus.OutCb, bus.OutCr};
  endfunction

  task automatic compare_pop();
    exp_t e;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_out actual=OutValid=1 required=no pending pixel");
    end else begin
      e = q.pop_front();
      chk("latency", ready_edges - e.acc, 4);
      chk("out_y", int'($signed(bus.OutY)), e.y);
      chk("out_cb", int'($signed(bus.OutCb)), e.cb);
      chk("out_cr", int'($signed(bus.OutCr)), e.cr);
      chk("block_x", int'(bus.OutBlockX), e.bx);
      chk("block_y", int'(bus.OutBlockY), e.by);
      chk("addr_y", int'(bus.OutAddressY), e.ay);
      chk("addr_cbcr", int'(bus.OutAddressCbCr), e.ac);
      chk("chroma_valid", int'(bus.OutChromaValid), e.cv);
      chk("mcu_last", int'(bus.OutMcuLast), e.ml);
    end
  endtask

  // One clock: drive at negedge, check outputs 1 time unit after the rising edge.
  task automatic cycle(input bit v, input int r, g, b, x, y, w, h,
                       input bit rdy, input bit rs, input exp_t e_in);
    logic [69:0] snap;
    exp_t e;
    e = e_in;
    @(negedge clk);
    rst              = rs;
    bus.InValid      = v;
    bus.InR          = r[7:0];
    bus.InG          = g[7:0];
    bus.InB          = b[7:0];
    bus.InPixelX     = x[15:0];
    bus.InPixelY     = y[15:0];
    bus.SubSamplingW = w[1:0];
    bus.SubSamplingH = h[1:0];
    bus.OutReady     = rdy;
    #1;
    chk("in_ready", int'(bus.InReady), int'(rdy));
    snap = outs();
    if (v && rdy && !rs) begin
      e.acc = ready_edges + 1;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      chk("reset_valid", int'(bus.OutValid), 0);
      chk("reset_outs_zero", int'(outs() == 70'd0), 1);
    end else if (rdy) begin
      ready_edges++;
      if (bus.OutValid) compare_pop();
    end else begin
      chk("stall_hold", int'(outs() === snap), 1);
    end
  endtask

  task automatic bubble(input bit rdy);
    cycle(1'b0, 0, 0, 0, 0, 0, 1, 1, rdy, 1'b0, nil);
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && q.size() > 0; k++) bubble(1'b1);
    chk("drain_pending", q.size(), 0);
  endtask

  task automatic send(input int r, g, b, x, y, w, h, input bit rdy);
    cycle(1'b1, r, g, b, x, y, w, h, rdy, 1'b0, model(r, g, b, x, y, w, h));
  endtask

  initial begin
    exp_t e;
    int   i;
    rst = 1'b1;
    bus.InValid = 1'b0; bus.OutReady = 1'b1;
    bus.InR = 8'd0; bus.InG = 8'd0; bus.InB = 8'd0;
    bus.InPixelX = 16'd0; bus.InPixelY = 16'd0;
    bus.SubSamplingW = 2'd1; bus.SubSamplingH = 2'd1;

    //          r    g    b    x        y       w  h   Y    Cb   Cr  bx by ay     ac     cv ml
    tbl[0] = '{255, 255, 255, 0,       0,      1, 1,  127,   0,   0, 0, 0, 'h00, 'h00, 1, 0};
    tbl[1] = '{0,   0,   0,   1,       0,      1, 1, -128,   0,   0, 0, 0, 'h01, 'h02, 1, 0};
    tbl[2] = '{255, 0,   0,   2,       0,      1, 1,  -52, -43, 127, 0, 0, 'h02, 'h04, 1, 0};
    tbl[3] = '{0,   0,   255, 3,       0,      1, 1,  -99, 127, -21, 0, 0, 'h03, 'h06, 1, 0};
    tbl[4] = '{0,   0,   0,   'h16,    'h24,   2, 2, -128,   0,   0, 1, 2, 'h46, 'h46, 1, 0};
    tbl[5] = '{255, 255, 255, 'h17,    'h24,   2, 2,  127,   0,   0, 1, 2, 'h47, 'h46, 0, 0};
    tbl[6] = '{255, 0,   0,   'h1F,    'h2F,   2, 2,  -52, -43, 127, 1, 2, 'hFF, 'hEE, 0, 1};
    tbl[7] = '{0,   0,   255, 7,       7,      1, 1,  -99, 127, -21, 0, 0, 'h77, 'hEE, 1, 1};
    tbl[8] = '{0,   0,   0,   'h8009,  'h12,   3, 0, -128,   0,   0, 1, 2, 'h21, 'h42, 1, 0};
    tbl[9] = '{255, 255, 255, 'h35,    'hA,    2, 1,  127,   0,   0, 3, 1, 'h25, 'h44, 0, 0};

    cycle(1'b0, 0, 0, 0, 0, 0, 1, 1, 1'b1, 1'b1, nil);
    cycle(1'b0, 0, 0, 0, 0, 0, 1, 1, 1'b0, 1'b1, nil);

    // Directed vectors, back to back.
    for (int k = 0; k < 10; k++) begin
      e = '{tbl[k].ey, tbl[k].ecb, tbl[k].ecr, tbl[k].ebx, tbl[k].eby,
            tbl[k].eay, tbl[k].eac, tbl[k].ecv, tbl[k].eml, 0};
      cycle(1'b1, tbl[k].r, tbl[k].g, tbl[k].b, tbl[k].x, tbl[k].y, tbl[k].w, tbl[k].h,
            1'b1, 1'b0, e);
    end
    drain();

    // Ten pixels with a three-cycle OutReady stall while outputs are valid.
    i = 0;
    for (int c = 0; c < 40 && i < 10; c++) begin
      bit rdy = !(c >= 5 && c < 8);
      send(i * 25, 255 - i * 20, i * 13, i, 5, 1, 1, rdy);
      if (rdy) i++;
    end
    chk("stall_stream_sent", i, 10);
    drain();

    // Reset with three pixels in flight: none of them may emerge.
    send(10, 20, 30, 0, 0, 1, 1, 1'b1);
    send(40, 50, 60, 1, 0, 1, 1, 1'b1);
    send(70, 80, 90, 2, 0, 1, 1, 1'b1);
    cycle(1'b0, 0, 0, 0, 0, 0, 1, 1, 1'b1, 1'b1, nil);
    for (int k = 0; k < 5; k++) bubble(1'b1);
    send(200, 100, 50, 8, 8, 2, 2, 1'b1);
    send(1, 2, 3, 9, 8, 2, 2, 1'b1);
    drain();

    // Randomized traffic with bubbles, stalls and all sampling ratio codes.
    for (int k = 0; k < 400; k++) begin
      int r = ($urandom_range(0, 3) == 0) ? 255 * $urandom_range(0, 1) : $urandom_range(0, 255);
      int g = ($urandom_range(0, 3) == 0) ? 255 * $urandom_range(0, 1) : $urandom_range(0, 255);
      int b = ($urandom_range(0, 3) == 0) ? 255 * $urandom_range(0, 1) : $urandom_range(0, 255);
      int x = $urandom_range(0, 65535);
      int y = $urandom_range(0, 65535);
      int w = $urandom_range(0, 3);
      int h = $urandom_range(0, 3);
      bit v = ($urandom_range(0, 3) != 0);
      bit rdy = ($urandom_range(0, 4) != 0);
      cycle(v, r, g, b, x, y, w, h, rdy, 1'b0, model(r, g, b, x, y, w, h));
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
